reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Generates the block-level reset that counters and datapath modules consume on their own resetN input.
- Takes the raw board reset, synchronises its release, stretches it to a minimum width and releases it cleanly on a clock edge.
- Also services software and external reset-hold requests.
- Downstream blocks therefore never see a reset that releases at simulation time zero or mid-cycle.

Parameters:
- SYNC_STAGES, 2: depth of the release synchroniser on resetN; legal range 2..4.
- HOLD_CYCLES, 16: clock cycles rst_out_n is held low after the synchronised release; legal range 1..255.
- SW_HOLD_CYCLES, 8: clock cycles rst_out_n is held low for a software reset; legal range 1..255.
- CNT_W, 16: width of the software-reset event counter.

Ports:
- clock, input, 1: system clock, rising edge.
- resetN, input, 1: raw reset, asynchronous, active-low.
- sw_reset_req, input, 1: synchronous software reset request, sampled each rising edge.
- ext_hold, input, 1: synchronous request to hold downstream in reset while high.
- rst_out_n, output, 1: downstream reset, active-low; asserts asynchronously, deasserts only on a rising clock edge.
- rst_done, output, 1: high while downstream is out of reset and stable.
- rst_cause, output, 2: cause of the last reset: 01 POR, 10 SW, 11 EXT; 00 is never driven.
- sw_rst_count, output, CNT_W: number of software resets since the last resetN; saturates at all-ones.

Behaviour:
- Clock is clock. Reset is resetN, asynchronous, active-low.
- While resetN = 0, all of the following hold immediately and without a clock:
  - rst_out_n = 0, rst_done = 0, rst_cause = 01, sw_rst_count = 0.
  - Synchroniser flops = 0, hold counter = 0, state = ASSERT.
- Synchroniser: a SYNC_STAGES-deep flop chain shifts in 1 while resetN = 1. sync_ok is the last stage.
- FSM states are ASSERT, HOLD, RELEASE, RUN and SWRST. All transitions occur on rising edges.
  - ASSERT: rst_out_n = 0. When sync_ok = 1 is sampled, go to HOLD and load cnt = HOLD_CYCLES-1.
  - HOLD: rst_out_n = 0.
    - If ext_hold = 1, reload cnt = HOLD_CYCLES-1 and stay in HOLD.
    - Else if cnt == 0, go to RELEASE and register rst_out_n <= 1.
    - Else decrement cnt.
  - RELEASE: rst_out_n = 1, rst_done = 0. Next edge goes to RUN and sets rst_done <= 1.
  - RUN: rst_out_n = 1, rst_done = 1. Priority at each edge is ext_hold over sw_reset_req.
    - ext_hold = 1: go to HOLD, rst_out_n <= 0, rst_done <= 0, rst_cause <= 11, cnt = HOLD_CYCLES-1.
    - sw_reset_req = 1: go to SWRST, rst_out_n <= 0, rst_done <= 0, rst_cause <= 10, cnt = SW_HOLD_CYCLES-1, sw_rst_count increments (saturating).
  - SWRST: rst_out_n = 0. Count down exactly as in HOLD, but ext_hold is ignored. When cnt == 0, go to RELEASE and set rst_out_n <= 1.
- sw_reset_req is ignored in every state except RUN. A request held high for N cycles produces one SW reset per entry into RUN. It is not queued.
- rst_out_n and rst_done are direct flop outputs: no combinational path from any input except the asynchronous clear from resetN.
- POR release timing: number the first rising edge after resetN rises as edge 1.
  - rst_out_n rises at edge SYNC_STAGES+1+HOLD_CYCLES.
  - rst_done rises one edge later.
- resetN low at any point, in any state, mid-count: immediate return to the full reset values listed above. sw_rst_count is cleared.
- resetN glitch shorter than one clock period: still a full asynchronous reset, followed by a full POR sequence.
- Counter width: cnt is 8 bits. HOLD_CYCLES and SW_HOLD_CYCLES are never 0.

Test Plan:
- POR, clock period 20, defaults; resetN = 0 at t = 0, resetN = 1 at t = 2:
  - rst_out_n = 0 from t = 0.
  - rst_out_n = 1 at edge 19; rst_done = 1 at edge 20; rst_cause = 01; sw_rst_count = 0.
  - An attached 16-bit counter reads 0 at t = 3 and is still 0 through edge 18.
- SW reset: in RUN, pulse sw_reset_req for 1 cycle, sampled at edge k:
  - rst_out_n = 0 from edge k through edge k+7; rst_out_n = 1 at edge k+8; rst_done = 1 at edge k+9.
  - rst_cause = 10; sw_rst_count = 1.
- sw_reset_req held high for 40 cycles with defaults:
  - Back-to-back SW resets, each 8 cycles low, 1 cycle in RELEASE, 1 cycle in RUN.
  - sw_rst_count increments once per entry into RUN.
- ext_hold high for 30 cycles during RUN:
  - rst_out_n stays 0 for the full 30 cycles, then for 16 more cycles.
  - rst_cause = 11.
  - Simultaneous sw_reset_req and ext_hold in RUN selects EXT.
- resetN dropped mid-SWRST at cnt = 3:
  - rst_out_n stays 0 with no edge.
  - sw_rst_count = 0, rst_cause = 01.
  - On resetN release, a full 19-edge POR sequence follows.
- Saturation with CNT_W = 2: after 5 SW resets, sw_rst_count = 3.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Produces the block-level reset consumed by counters and datapath modules.
// The raw board reset asserts the output immediately (asynchronously); its
// release is synchronised, stretched to HOLD_CYCLES and then released on a
// rising clock edge. In normal operation the block also services a software
// reset request (fixed SW_HOLD_CYCLES pulse) and an external hold request
// (output stays low while held, then HOLD_CYCLES more).
//
// Ports
//   clock         system clock, rising edge
//   resetN        raw reset, asynchronous, active-low
//   sw_reset_req  software reset request, sampled every rising edge (RUN only)
//   ext_hold      hold downstream in reset while high (RUN and HOLD only)
//   rst_out_n     downstream reset, active-low, flop output
//   rst_done      high while downstream is out of reset and stable, flop output
//   rst_cause     cause of last reset: 01 POR, 10 SW, 11 EXT
//   sw_rst_count  software resets since last resetN, saturating
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned SW_HOLD_CYCLES = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             sw_reset_req,
  input  logic             ext_hold,
  output logic             rst_out_n,
  output logic             rst_done,
  output logic [1:0]       rst_cause,
  output logic [CNT_W-1:0] sw_rst_count
);

  localparam logic [1:0] CausePor = 2'b01;
  localparam logic [1:0] CauseSw  = 2'b10;
  localparam logic [1:0] CauseExt = 2'b11;

  // Reload values: the counter runs from N-1 down to 0, and the release
  // happens on the edge that samples 0, giving N low edges from the load.
  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SwLoad   = 8'(SW_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StAssert  = 3'd0,
    StHold    = 3'd1,
    StRelease = 3'd2,
    StRun     = 3'd3,
    StSwRst   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Release synchroniser: asserts with resetN, shifts in ones after release.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             rst_out_q;
  logic             done_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] swcnt_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StAssert;
      cnt_q     <= '0;
      rst_out_q <= 1'b0;
      done_q    <= 1'b0;
      cause_q   <= CausePor;
      swcnt_q   <= '0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (sync_ok) begin
            state_q <= StHold;
            cnt_q   <= HoldLoad;
          end
        end

        StHold: begin
          if (ext_hold) begin
            cnt_q <= HoldLoad;
          end else if (cnt_q == 8'd0) begin
            state_q   <= StRelease;
            rst_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        StRelease: begin
          state_q <= StRun;
          done_q  <= 1'b1;
        end

        StRun: begin
          // External hold wins over a simultaneous software request.
          if (ext_hold) begin
            state_q   <= StHold;
            rst_out_q <= 1'b0;
            done_q    <= 1'b0;
            cause_q   <= CauseExt;
            cnt_q     <= HoldLoad;
          end else if (sw_reset_req) begin
            state_q   <= StSwRst;
            rst_out_q <= 1'b0;
            done_q    <= 1'b0;
            cause_q   <= CauseSw;
            cnt_q     <= SwLoad;
            if (swcnt_q != '1) begin
              swcnt_q <= swcnt_q + CNT_W'(1);
            end
          end
        end

        StSwRst: begin
          // ext_hold deliberately not honoured here.
          if (cnt_q == 8'd0) begin
            state_q   <= StRelease;
            rst_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        default: begin
          state_q   <= StAssert;
          rst_out_q <= 1'b0;
          done_q    <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign rst_out_n    = rst_out_q;
  assign rst_done     = done_q;
  assign rst_cause    = cause_q;
  assign sw_rst_count = swcnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
// Bench for reset_sequencer. Two instances share all stimulus: the default
// one and a CNT_W = 2 one used to observe counter saturation. Each reset
// event issued by the stimulus pushes its expected outcome; the monitor pops
// one entry every time rst_done rises and checks cause, counts, low width
// and release-to-done spacing.
module tb_reset_sequencer;

  localparam int unsigned SyncStages   = 2;
  localparam int unsigned HoldCycles   = 16;
  localparam int unsigned SwHoldCycles = 8;

  logic        clock = 1'b0;
  logic        resetN;
  logic        sw_reset_req = 1'b0;
  logic        ext_hold = 1'b0;
  logic        rst_out_n;
  logic        rst_done;
  logic [1:0]  rst_cause;
  logic [15:0] sw_rst_count;
  logic        rst_out_n2;
  logic        rst_done2;
  logic [1:0]  rst_cause2;
  logic [1:0]  sw_rst_count2;

  always #10 clock = ~clock;

  reset_sequencer #(
    .SYNC_STAGES   (SyncStages),
    .HOLD_CYCLES   (HoldCycles),
    .SW_HOLD_CYCLES(SwHoldCycles),
    .CNT_W         (16)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .sw_reset_req(sw_reset_req),
    .ext_hold    (ext_hold),
    .rst_out_n   (rst_out_n),
    .rst_done    (rst_done),
    .rst_cause   (rst_cause),
    .sw_rst_count(sw_rst_count)
  );

  reset_sequencer #(
    .SYNC_STAGES   (SyncStages),
    .HOLD_CYCLES   (HoldCycles),
    .SW_HOLD_CYCLES(SwHoldCycles),
    .CNT_W         (2)
  ) dut_sat (
    .clock       (clock),
    .resetN      (resetN),
    .sw_reset_req(sw_reset_req),
    .ext_hold    (ext_hold),
    .rst_out_n   (rst_out_n2),
    .rst_done    (rst_done2),
    .rst_cause   (rst_cause2),
    .sw_rst_count(sw_rst_count2)
  );

  // Downstream counter held in reset by rst_out_n.
  logic [15:0] acnt;
  always_ff @(posedge clock or negedge rst_out_n) begin
    if (!rst_out_n) acnt <= '0;
    else            acnt <= acnt + 16'd1;
  end

  typedef struct {
    logic [1:0] cause;
    int         count;
    int         sat;
    int         low;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   sw_total = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [1:0] cause, input int low);
    exp_t e;
    e.cause = cause;
    e.count = sw_total;
    e.sat   = (sw_total > 3) ? 3 : sw_total;
    e.low   = low;
    exp_q.push_back(e);
  endtask

  task automatic wait_run(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clock);
      #1;
      if (rst_done) ok = 1'b1;
    end
    if (!ok) check("wait_run_timeout", 0, 1);
  endtask

  // Monitor: measures low width in rising edges and pops on rst_done rise.
  int   low_cnt = 0;
  int   low_len = 0;
  int   rise_edges = 0;
  logic prev_out = 1'b0;
  logic prev_done = 1'b0;

  always begin
    @(posedge clock);
    #1;
    if (!resetN) begin
      low_cnt   = 0;
      prev_out  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (rst_out_n && !prev_out) begin
        low_len    = low_cnt;
        low_cnt    = 0;
        rise_edges = 0;
      end else if (rst_out_n) begin
        rise_edges++;
      end
      if (!rst_out_n) low_cnt++;
      if (rst_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_release", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_cause", int'(rst_cause), int'(mon_e.cause));
          check("sb_sw_count", int'(sw_rst_count), mon_e.count);
          check("sb_sw_count_sat", int'(sw_rst_count2), mon_e.sat);
          check("sb_low_edges", low_len, mon_e.low);
          check("sb_done_after_release", rise_edges, 1);
        end
      end
      prev_out  = rst_out_n;
      prev_done = rst_done;
    end
  end

  // Count edges after a resetN release and check the release point.
  task automatic por_edges();
    for (int e = 1; e <= int'(SyncStages + 1 + HoldCycles); e++) begin
      @(posedge clock);
      #1;
      if (e == int'(SyncStages + HoldCycles)) begin
        check("por_out_low_edge18", int'(rst_out_n), 0);
        check("por_counter_held", int'(acnt), 0);
      end
      if (e == int'(SyncStages + 1 + HoldCycles)) begin
        check("por_out_high_edge19", int'(rst_out_n), 1);
        check("por_done_low_edge19", int'(rst_done), 0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Start high so the drop is a real falling edge for the async clear.
    resetN = 1'b1;
    push(2'b01, int'(SyncStages + HoldCycles));
    #0.1 resetN = 1'b0;
    #0.9;
    check("rst_out_n_in_reset", int'(rst_out_n), 0);
    check("rst_done_in_reset", int'(rst_done), 0);
    check("rst_cause_in_reset", int'(rst_cause), 1);
    check("sw_count_in_reset", int'(sw_rst_count), 0);
    #1 resetN = 1'b1;
    #1;
    check("counter_t3", int'(acnt), 0);
    check("rst_out_n_t3", int'(rst_out_n), 0);
    por_edges();
    wait_run(10);

    // Single software reset pulse.
    @(negedge clock);
    sw_reset_req = 1'b1;
    sw_total++;
    push(2'b10, int'(SwHoldCycles));
    @(negedge clock);
    sw_reset_req = 1'b0;
    check("sw_out_low", int'(rst_out_n), 0);
    wait_run(30);
    check("sw_cause_direct", int'(rst_cause), 2);

    // Request held for 40 cycles: four back-to-back resets.
    @(negedge clock);
    sw_reset_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sw_total++;
      push(2'b10, int'(SwHoldCycles));
    end
    repeat (40) @(posedge clock);
    @(negedge clock);
    sw_reset_req = 1'b0;
    wait_run(30);

    // External hold for 30 cycles.
    @(negedge clock);
    ext_hold = 1'b1;
    push(2'b11, 30 + int'(HoldCycles) - 1);
    repeat (30) @(posedge clock);
    @(negedge clock);
    ext_hold = 1'b0;
    check("ext_out_low", int'(rst_out_n), 0);
    wait_run(60);

    // Simultaneous requests: external hold wins, count unchanged.
    @(negedge clock);
    ext_hold = 1'b1;
    sw_reset_req = 1'b1;
    push(2'b11, int'(HoldCycles));
    @(negedge clock);
    ext_hold = 1'b0;
    sw_reset_req = 1'b0;
    wait_run(30);
    check("simul_count", int'(sw_rst_count), 5);

    // Software reset aborted by resetN with cnt = 3.
    @(negedge clock);
    sw_reset_req = 1'b1;
    sw_total++;
    @(negedge clock);
    sw_reset_req = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("swrst_out_low", int'(rst_out_n), 0);
    check("swrst_count6", int'(sw_rst_count), 6);
    check("swrst_count_sat", int'(sw_rst_count2), 3);
    resetN = 1'b0;
    sw_total = 0;
    #1;
    check("abort_out_low", int'(rst_out_n), 0);
    check("abort_done_low", int'(rst_done), 0);
    check("abort_cause_por", int'(rst_cause), 1);
    check("abort_count_clear", int'(sw_rst_count), 0);
    check("abort_sat_clear", int'(sw_rst_count2), 0);
    push(2'b01, int'(SyncStages + HoldCycles));
    repeat (2) @(posedge clock);
    #3 resetN = 1'b1;
    por_edges();
    wait_run(10);

    // Count restarts from zero after the board reset.
    @(negedge clock);
    sw_reset_req = 1'b1;
    sw_total++;
    push(2'b10, int'(SwHoldCycles));
    @(negedge clock);
    sw_reset_req = 1'b0;
    wait_run(30);

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
